// File: rtl/frodo_macs.sv
// frodo_macs: 4-lane pipelined multiply-accumulate for Frodo A*S / S*A + E.
// Ports: clk, rst (sync, active-high), level, macs_en/macs_signal/macs_mode,
//        long_data, short_data, add_data in; macs_result(_valid), macs_busy out.
module frodo_macs #(
    parameter int LANES   = 4,
    parameter int COEF_W  = 16,
    parameter int SHORT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                level,
    input  logic                      macs_en,
    input  logic                      macs_signal,
    input  logic                      macs_mode,
    input  logic [LANES*COEF_W-1:0]   long_data,
    input  logic [LANES*SHORT_W-1:0]  short_data,
    input  logic [LANES*COEF_W-1:0]   add_data,
    output logic [LANES*COEF_W-1:0]   macs_result,
    output logic                      macs_result_valid,
    output logic                      macs_busy
);

    localparam int DW = LANES * COEF_W;
    localparam int SW = LANES * SHORT_W;

    function automatic logic [COEF_W-1:0] lane_mul(
        input logic [COEF_W-1:0]  l,
        input logic [SHORT_W-1:0] s
    );
        logic [COEF_W-1:0] sx;
        sx = {{(COEF_W-SHORT_W){s[SHORT_W-1]}}, s};
        return l * sx;
    endfunction

    logic          group_open_q, group_open_d;
    logic          mode_q, mode_d;
    logic          first_beat;

    logic          s1_v_q, s1_v_d;
    logic          s1_first_q, s1_first_d;
    logic          s1_last_q, s1_last_d;
    logic          s1_mode_q, s1_mode_d;
    logic          s1_lvl0_q, s1_lvl0_d;
    logic [DW-1:0] s1_long_q, s1_long_d;
    logic [SW-1:0] s1_short_q, s1_short_d;
    logic [DW-1:0] s1_add_q, s1_add_d;

    logic          s2_v_q, s2_v_d;
    logic          s2_first_q, s2_first_d;
    logic          s2_last_q, s2_last_d;
    logic          s2_mode_q, s2_mode_d;
    logic          s2_lvl0_q, s2_lvl0_d;
    logic [DW-1:0] s2_prod_q, s2_prod_d;
    logic [DW-1:0] s2_add_q, s2_add_d;

    logic          s3_v_q, s3_v_d;
    logic          s3_last_q, s3_last_d;
    logic          s3_lvl0_q, s3_lvl0_d;
    logic [DW-1:0] s3_acc_q, s3_acc_d;

    logic [DW-1:0] result_q, result_d;
    logic          valid_q, valid_d;

    logic [DW-1:0]     base;
    logic [COEF_W-1:0] red_sum;
    logic [COEF_W-1:0] mask;

    // Framing and stage 1: operand capture
    always_comb begin
        first_beat   = macs_en & ~group_open_q;
        group_open_d = macs_en ? ~macs_signal : group_open_q;
        mode_d       = first_beat ? macs_mode : mode_q;
        s1_v_d       = macs_en;
        s1_first_d   = first_beat;
        s1_last_d    = macs_en & macs_signal;
        s1_mode_d    = mode_d;
        s1_lvl0_d    = (level == 2'd0);
        s1_long_d    = long_data;
        s1_short_d   = short_data;
        s1_add_d     = add_data;
    end

    // Stage 2: truncated lane products
    always_comb begin
        s2_v_d     = s1_v_q;
        s2_first_d = s1_first_q;
        s2_last_d  = s1_last_q;
        s2_mode_d  = s1_mode_q;
        s2_lvl0_d  = s1_lvl0_q;
        s2_add_d   = s1_add_q;
        s2_prod_d  = '0;
        for (int i = 0; i < LANES; i++) begin
            s2_prod_d[i*COEF_W +: COEF_W] =
                lane_mul(s1_long_q[i*COEF_W +: COEF_W],
                         s1_short_q[i*SHORT_W +: SHORT_W]);
        end
    end

    // Stage 3: accumulate; a first beat restarts from the seed
    always_comb begin
        s3_v_d    = s2_v_q;
        s3_last_d = s2_last_q;
        s3_lvl0_d = s2_lvl0_q;
        base      = s2_first_q ? s2_add_q : s3_acc_q;
        red_sum   = base[COEF_W-1:0];
        for (int i = 0; i < LANES; i++) begin
            red_sum = red_sum + s2_prod_q[i*COEF_W +: COEF_W];
        end
        s3_acc_d = s3_acc_q;
        if (s2_v_q) begin
            if (s2_mode_q) begin
                s3_acc_d               = '0;
                s3_acc_d[COEF_W-1:0]   = red_sum;
            end else begin
                for (int i = 0; i < LANES; i++) begin
                    s3_acc_d[i*COEF_W +: COEF_W] =
                        base[i*COEF_W +: COEF_W] +
                        s2_prod_q[i*COEF_W +: COEF_W];
                end
            end
        end
    end

    // Output register: mask only here, level taken from the last beat
    always_comb begin
        mask     = s3_lvl0_q ? 16'h7FFF : 16'hFFFF;
        valid_d  = s3_v_q & s3_last_q;
        result_d = result_q;
        if (valid_d) begin
            result_d = s3_acc_q & {LANES{mask}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            group_open_q <= 1'b0;
            mode_q       <= 1'b0;
            s1_v_q       <= 1'b0;
            s1_first_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_mode_q    <= 1'b0;
            s1_lvl0_q    <= 1'b0;
            s1_long_q    <= '0;
            s1_short_q   <= '0;
            s1_add_q     <= '0;
            s2_v_q       <= 1'b0;
            s2_first_q   <= 1'b0;
            s2_last_q    <= 1'b0;
            s2_mode_q    <= 1'b0;
            s2_lvl0_q    <= 1'b0;
            s2_prod_q    <= '0;
            s2_add_q     <= '0;
            s3_v_q       <= 1'b0;
            s3_last_q    <= 1'b0;
            s3_lvl0_q    <= 1'b0;
            s3_acc_q     <= '0;
            result_q     <= '0;
            valid_q      <= 1'b0;
        end else begin
            group_open_q <= group_open_d;
            mode_q       <= mode_d;
            s1_v_q       <= s1_v_d;
            s1_first_q   <= s1_first_d;
            s1_last_q    <= s1_last_d;
            s1_mode_q    <= s1_mode_d;
            s1_lvl0_q    <= s1_lvl0_d;
            s1_long_q    <= s1_long_d;
            s1_short_q   <= s1_short_d;
            s1_add_q     <= s1_add_d;
            s2_v_q       <= s2_v_d;
            s2_first_q   <= s2_first_d;
            s2_last_q    <= s2_last_d;
            s2_mode_q    <= s2_mode_d;
            s2_lvl0_q    <= s2_lvl0_d;
            s2_prod_q    <= s2_prod_d;
            s2_add_q     <= s2_add_d;
            s3_v_q       <= s3_v_d;
            s3_last_q    <= s3_last_d;
            s3_lvl0_q    <= s3_lvl0_d;
            s3_acc_q     <= s3_acc_d;
            result_q     <= result_d;
            valid_q      <= valid_d;
        end
    end

    assign macs_result       = result_q;
    assign macs_result_valid = valid_q;
    assign macs_busy         = group_open_q | s1_v_q | s2_v_q | s3_v_q;

endmodule
